// File: rtl/inst_sram_resp.sv
// Responder end of the fetch-stage instruction SRAM: word memory with byte-lane writes,
// 1-cycle registered reads that hold while idle, plus out-of-range flag and access counters.
module inst_sram_resp #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h1c00_0000,
    parameter logic [31:0] OOR_DATA   = 32'h0340_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sram_en,
    input  logic [3:0]  sram_we,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic        oor_err,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned IDX_W = DEPTH_LOG2;
    // Byte span of the array; one extra bit so a full 4 GiB map still compares correctly.
    localparam logic [32:0] SPAN  = 33'(33'd4 << DEPTH_LOG2);

    logic [31:0]      mem [DEPTH];

    logic [31:0]      off;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             is_read;
    logic             is_write;

    // Address decode: wrap-around offset from the base, word index ignores addr[1:0].
    assign off      = sram_addr - BASE_ADDR;
    assign in_range = {1'b0, off} < SPAN;
    assign idx      = off[IDX_W+1:2];
    assign is_read  = sram_en && (sram_we == 4'b0000);
    assign is_write = sram_en && (sram_we != 4'b0000);

    // Memory array is never reset so a preloaded image survives reset.
    always_ff @(posedge clk) begin
        if (resetn && is_write && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (sram_we[i]) begin
                    mem[idx][8*i +: 8] <= sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read data only moves on a read, so a stalled fetch sees a stable word.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sram_rdata <= 32'h0;
        end else if (is_read) begin
            sram_rdata <= in_range ? mem[idx] : OOR_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            oor_err <= 1'b0;
        end else if (sram_en && !in_range) begin
            oor_err <= 1'b1;
        end
    end

    // Saturating access counters.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_cnt <= 32'h0;
            wr_cnt <= 32'h0;
        end else begin
            if (is_read && (rd_cnt != 32'hffff_ffff)) begin
                rd_cnt <= rd_cnt + 32'd1;
            end
            if (is_write && (wr_cnt != 32'hffff_ffff)) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_inst_sram_resp.sv
// Bench for inst_sram_resp: directed vector table, reset-mid-stream sequence and
// randomized traffic checked against a word-array reference model.
module tb_inst_sram_resp;

    localparam logic [31:0] BASE = 32'h1c00_0000;
    localparam logic [31:0] NOP  = 32'h0340_0000;
    localparam int unsigned WORDS = 4096;

    logic        clk;
    logic        resetn;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        oor_err;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    inst_sram_resp dut (
        .clk        (clk),
        .resetn     (resetn),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .oor_err    (oor_err),
        .rd_cnt     (rd_cnt),
        .wr_cnt     (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model state
    logic [31:0] m_mem [WORDS];
    bit          m_val [WORDS];
    logic [31:0] m_rdata;
    bit          m_known;
    bit          m_oor;
    longint      m_rd;
    longint      m_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    task automatic model(input logic rst, input logic en, input logic [3:0] we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        longint off;
        int     w;
        if (!rst) begin
            m_rdata = 0; m_known = 1; m_oor = 0; m_rd = 0; m_wr = 0;
        end else if (en) begin
            off = longint'(addr) - longint'(BASE);
            if (off < 0) off += 64'h1_0000_0000;
            w = int'(off / 4);
            if (off >= 4 * WORDS) m_oor = 1;
            if (we == 4'b0) begin
                if (m_rd < 64'hffff_ffff) m_rd++;
                if (off >= 4 * WORDS) begin
                    m_rdata = NOP; m_known = 1;
                end else begin
                    m_rdata = m_mem[w]; m_known = m_val[w];
                end
            end else begin
                if (m_wr < 64'hffff_ffff) m_wr++;
                if (off < 4 * WORDS) begin
                    for (int i = 0; i < 4; i++)
                        if (we[i]) m_mem[w][8*i +: 8] = wdata[8*i +: 8];
                    if (we == 4'hf) m_val[w] = 1;
                end
            end
        end
    endtask

    // Drive one cycle, advance the model, compare all outputs just after the edge.
    task automatic step(input logic rst, input logic en, input logic [3:0] we,
                        input logic [31:0] addr, input logic [31:0] wdata);
        resetn = rst; sram_en = en; sram_we = we; sram_addr = addr; sram_wdata = wdata;
        @(posedge clk);
        #1;
        model(rst, en, we, addr, wdata);
        if (m_known) chk("model_rdata", sram_rdata, m_rdata);
        chk("model_oor", {31'b0, oor_err}, {31'b0, m_oor});
        chk("model_rd_cnt", rd_cnt, 32'(m_rd));
        chk("model_wr_cnt", wr_cnt, 32'(m_wr));
    endtask

    typedef struct {
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_oor;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, input logic [3:0] we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] er, input logic eo);
        vec_t v;
        v.en = en; v.we = we; v.addr = addr; v.wdata = wdata; v.exp_rdata = er; v.exp_oor = eo;
        return v;
    endfunction

    initial begin
        logic [31:0] a;
        logic [3:0]  we;
        int          sel;

        for (int i = 0; i < WORDS; i++) begin
            m_val[i] = 0;
            m_mem[i] = 32'h0;
        end
        resetn = 0; sram_en = 0; sram_we = 0; sram_addr = 0; sram_wdata = 0;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("reset_rdata", sram_rdata, 32'h0);
        chk("reset_oor", {31'b0, oor_err}, 32'h0);
        chk("reset_rd_cnt", rd_cnt, 32'h0);
        chk("reset_wr_cnt", wr_cnt, 32'h0);

        // Preload, back-to-back reads, idle hold
        vecs.push_back(mk(1, 4'hf, BASE + 32'h0,    32'h11,        32'h0, 0));
        vecs.push_back(mk(1, 4'hf, BASE + 32'h4,    32'h22,        32'h0, 0));
        vecs.push_back(mk(1, 4'hf, BASE + 32'h8,    32'h33,        32'h0, 0));
        vecs.push_back(mk(1, 4'hf, BASE + 32'hc,    32'h44,        32'h0, 0));
        vecs.push_back(mk(1, 4'hf, BASE + 32'h3ffc, 32'h5555aaaa,  32'h0, 0));
        vecs.push_back(mk(1, 4'h0, BASE + 32'h0,    32'h0,         32'h11, 0));
        vecs.push_back(mk(1, 4'h0, BASE + 32'h4,    32'h0,         32'h22, 0));
        vecs.push_back(mk(1, 4'h0, BASE + 32'h8,    32'h0,         32'h33, 0));
        vecs.push_back(mk(1, 4'h0, BASE + 32'hc,    32'h0,         32'h44, 0));
        vecs.push_back(mk(1, 4'h0, BASE + 32'h4,    32'h0,         32'h22, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 4'h0, 32'h0, 32'hffffffff, 32'h22, 0));
        // Byte-lane write merge; rdata holds during writes
        vecs.push_back(mk(1, 4'hf, BASE + 32'h8,    32'h33333333,  32'h22, 0));
        vecs.push_back(mk(1, 4'h5, BASE + 32'h8,    32'haabbccdd,  32'h22, 0));
        vecs.push_back(mk(1, 4'h0, BASE + 32'h8,    32'h0,         32'h33bb33dd, 0));
        // Low address bits ignored
        vecs.push_back(mk(1, 4'h0, BASE + 32'h5,    32'h0,         32'h22, 0));
        // Top in-range word
        vecs.push_back(mk(1, 4'h0, BASE + 32'h3ffc, 32'h0,         32'h5555aaaa, 0));
        // Out-of-range accesses, sticky flag, no aliasing of OOR writes
        vecs.push_back(mk(1, 4'h0, 32'h1bfffffc,    32'h0,         NOP, 1));
        vecs.push_back(mk(1, 4'h0, BASE + 32'h4000, 32'h0,         NOP, 1));
        vecs.push_back(mk(1, 4'hf, BASE + 32'h4000, 32'hdeadbeef,  NOP, 1));
        vecs.push_back(mk(1, 4'hf, 32'h1bfffffc,    32'hdeadbeef,  NOP, 1));
        vecs.push_back(mk(1, 4'h0, BASE + 32'h0,    32'h0,         32'h11, 1));
        vecs.push_back(mk(1, 4'h0, BASE + 32'h3ffc, 32'h0,         32'h5555aaaa, 1));

        foreach (vecs[i]) begin
            step(1, vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("vec%0d_rdata", i), sram_rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_oor", i), {31'b0, oor_err}, {31'b0, vecs[i].exp_oor});
            if (i == 8) begin
                chk("burst_rd_cnt", rd_cnt, 32'd4);
                chk("burst_wr_cnt", wr_cnt, 32'd5);
            end
            if (i == 17) chk("merge_wr_cnt", wr_cnt, 32'd7);
        end

        // Reset asserted mid-stream with a full write pending
        step(1, 1, 4'h0, BASE + 32'h4, 32'h0);
        step(0, 1, 4'hf, BASE + 32'h0, 32'hffffffff);
        chk("rst_mid_rdata", sram_rdata, 32'h0);
        chk("rst_mid_oor", {31'b0, oor_err}, 32'h0);
        chk("rst_mid_rd_cnt", rd_cnt, 32'h0);
        chk("rst_mid_wr_cnt", wr_cnt, 32'h0);
        step(1, 1, 4'h0, BASE, 32'h0);
        chk("first_fetch_rdata", sram_rdata, 32'h11);
        chk("first_fetch_rd_cnt", rd_cnt, 32'd1);

        // Fill the random window so every read has a known expectation
        for (int i = 0; i < 16; i++) begin
            a = BASE + 32'((i < 8 ? i : WORDS - 16 + i) * 4);
            step(1, 1, 4'hf, a, $urandom);
        end

        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4)      a = BASE + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            else if (sel < 8) a = BASE + 32'($urandom_range(WORDS - 8, WORDS - 1) * 4) + 32'($urandom_range(0, 3));
            else if (sel < 9) a = BASE + 32'h4000 + 32'($urandom_range(0, 64));
            else              a = BASE - 32'($urandom_range(1, 64));
            we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), we, a, $urandom);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
